sram_like_slave: RTL and testbench
==================================

# sram_like_slave

Responder end of the data-SRAM-like request interface issued by the execute stage. It accepts requests (`req`/`wr`/`size`/`wstrb`/`addr`/`wdata`) with `addr_ok`, queues them in order, and returns `data_ok`/`rdata` after a programmable latency. It is backed by an internal word-addressed memory. It sits on the CPU data port in place of a real bus bridge, and serves both simulation and FPGA bring-up.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index width; memory holds 2^ADDR_WIDTH 32-bit words.
- `DEPTH`, default 2: maximum outstanding (accepted, not yet answered) requests; power of two, ≥1.
- `RD_LAT`, default 2: cycles from acceptance to `data_ok` on an idle slave; ≥1.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `req` in 1: request valid.
- `wr` in 1: 1 = write, 0 = read.
- `size` in 2: 0 = byte, 1 = half, 2 = word. Informational only.
- `wstrb` in 4: byte write enables (writes only).
- `addr` in 32: byte address.
- `wdata` in 32: write data, already byte-replicated by the requester.
- `addr_ok` out 1: request accepted this cycle when `req & addr_ok`.
- `data_ok` out 1: one-cycle response pulse.
- `rdata` out 32: read data, valid only while `data_ok`.

## Operation
- Word index is `addr[ADDR_WIDTH+1:2]`. `addr[1:0]` and the upper bits are ignored, so addresses alias. `rdata` always returns the full word; byte/half extraction is the requester's job.
- `addr_ok = resetn & ~full`. It is independent of `req` and of a same-cycle pop, so there is no combinational path from `data_ok` to `addr_ok`.
- On acceptance, `{wr, index, wstrb, wdata}` is pushed into an in-order FIFO.
- Head-entry counter:
  - Loaded with `RD_LAT-1` when an entry becomes head: pushed into an empty FIFO, or exposed by a pop.
  - Decrements each cycle.
  - When it is zero and the head is valid, `data_ok` is registered high for the next cycle.
- Retirement, in the `data_ok` cycle:
  - Read: `rdata = mem[index]`.
  - Write: bytes with `wstrb[i]` set take `wdata[8i+7:8i]`; `rdata = 0`.
  - The entry pops.
- A write with `wstrb = 0` still retires with `data_ok` and leaves memory unchanged.
- Ordering: writes commit at retirement and responses leave strictly in acceptance order, so read-after-write through the queue is coherent.
- No cancel input. Every accepted request is answered even if the CPU flushes; the requester discards the responses.

## Timing
- Idle slave, request accepted in cycle T → `data_ok` in cycle T+`RD_LAT`.
- Back-to-back requests: the next head loads its counter in the pop cycle, giving one response per `RD_LAT` cycles (one per cycle when `RD_LAT = 1`).
- Full FIFO: `addr_ok` is low. It rises the cycle after a pop, even if a push and a pop would coincide.
- Push and pop in the same cycle on a non-full FIFO: occupancy is unchanged and both take effect.
- Reset (`resetn` low at an edge):
  - FIFO emptied and counter cleared.
  - `data_ok = 0`, `rdata = 0`; `addr_ok` is 0 while `resetn` is low.
  - Pending writes are discarded and never committed.
  - Memory contents are not reset.

## Configuration
- `SRAM_LIKE_RANDOM_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (seed `16'hACE1`, taps 16/14/13/11) advances every cycle and resets to the seed.
  - `addr_ok` is additionally gated by `~lfsr[0]`.
  - A head whose counter is zero waits while `lfsr[1]` is 1.
  - Order and data are unchanged; only latency varies.
- Undefined: fully deterministic timing as specified above.

## Structure
- Shared package holds:
  - The interface width constants (32-bit addr/data, 4-bit strobe).
  - The `size` encodings.
  - The LFSR seed and taps.
  - The packed FIFO entry typedef.
- One sub-module, `sram_like_req_fifo`: a synchronous FIFO parameterised by `DEPTH` and entry width, exposing `full`/`empty`/`push`/`pop`/`head`.
- Memory array, counter, response register and LFSR live in the top level.

## Test plan
- Reset; write `0x1000` ← `0xDEADBEEF`, `wstrb=1111`; read `0x1000`. Each `data_ok` arrives `RD_LAT` cycles after its acceptance, and the read returns `0xDEADBEEF`.
- Write `0x1000`, `wstrb=0010`, `wdata=0x0000AB00`, then read. Returns `0xDEADABEF`; the write response has `rdata=0`.
- With `DEPTH=2` and `RD_LAT=2`, hold `req` high for four reads. `addr_ok` drops after two accepts, re-rises the cycle after each pop, and the four responses come in order with the correct data.
- Accept a write to `0x2000` (old value `0x11111111`) and assert `resetn` low before its `data_ok`. No `data_ok` occurs; a read after reset returns `0x11111111`.
- Write with `wstrb=0000`. `data_ok` still pulses and memory is unchanged.
- With `SRAM_LIKE_RANDOM_STALL_EN` defined, run 1000 random reads/writes against a reference-memory scoreboard. There must be no mismatch, no lost response and no out-of-order response.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like data-port responder: bus widths,
// size encodings, stall-LFSR constants and the queued request record.
package sram_like_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Fibonacci taps 16/14/13/11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // The full word address is kept; the top slices its own index width from it
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-3:0] word_addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/sram_like_req_fifo.sv
// In-order request queue: synchronous FIFO with registered occupancy.
// Push while full and pop while empty are ignored.
module sram_like_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == NW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = store[rp];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        store[wp] <= din;
        wp        <= bump(wp);
      end
      if (do_pop) begin
        rp <= bump(rp);
      end
      count <= count + NW'(do_push) - NW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like data-port responder backed by a word memory; answers in order
// after RD_LAT cycles. Define SRAM_LIKE_RANDOM_STALL_EN for LFSR-driven stalls.
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 2,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam int EW = $bits(req_entry_t);

  logic [DATA_W-1:0]     mem [2**ADDR_WIDTH];
  req_entry_t            push_entry;
  req_entry_t            head;
  logic [EW-1:0]         head_bits;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic                  full;
  logic                  empty;
  logic [NW-1:0]         count;
  logic [NW-1:0]         count_nxt;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  data_ok_nxt;
  logic                  stall_acc;
  logic                  stall_ret;
  logic                  unused_bits;

`ifdef SRAM_LIKE_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall_acc = lfsr[0];
  assign stall_ret = lfsr[1];
`else
  assign stall_acc = 1'b0;
  assign stall_ret = 1'b0;
`endif

  // addr_ok never looks at data_ok: a slot freed by a pop shows up next cycle
  assign addr_ok = resetn & ~full & ~stall_acc;
  assign push    = req & addr_ok;
  assign pop     = data_ok;

  assign push_entry = '{wr: wr, word_addr: addr[ADDR_W-1:2], wstrb: wstrb, wdata: wdata};
  assign head       = req_entry_t'(head_bits);
  assign head_idx   = head.word_addr[ADDR_WIDTH-1:0];

  sram_like_req_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head_bits),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A new head appears when pushed into an empty queue or exposed by a pop;
  // data_ok is raised for the cycle in which that head's countdown has expired.
  assign count_nxt   = count + NW'(push) - NW'(pop);
  assign load        = (push & empty) | (pop & (count_nxt != '0));
  assign cnt_nxt     = load ? CW'(RD_LAT - 1) : ((cnt != '0) ? cnt - 1'b1 : cnt);
  assign data_ok_nxt = (count_nxt != '0) & (cnt_nxt == '0) & ~stall_ret;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      data_ok <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      data_ok <= data_ok_nxt;
    end
  end

  // Writes commit only when they retire, so a reset discards queued writes
  always_ff @(posedge clk) begin
    if (resetn && data_ok && head.wr) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (head.wstrb[i]) mem[head_idx][8*i +: 8] <= head.wdata[8*i +: 8];
      end
    end
  end

  assign rdata = (data_ok && !head.wr) ? mem[head_idx] : '0;

  assign unused_bits = ^{size, addr[1:0], head.word_addr};

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: directed vector table, corner-case sequences and
// random traffic checked against an in-order reference queue and memory.
module tb_sram_like_slave;

  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 2;
  localparam int RD_LAT     = 2;
  localparam int NWORDS     = 1 << ADDR_WIDTH;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        req    = 1'b0;
  logic        wr     = 1'b0;
  logic [1:0]  size   = 2'd2;
  logic [3:0]  wstrb  = 4'h0;
  logic [31:0] addr   = 32'h0;
  logic [31:0] wdata  = 32'h0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  sram_like_slave #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .wr     (wr),
    .size   (size),
    .wstrb  (wstrb),
    .addr   (addr),
    .wdata  (wdata),
    .addr_ok(addr_ok),
    .data_ok(data_ok),
    .rdata  (rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic        wr;
    int          idx;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          acc_cyc;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [NWORDS];
  bit          ref_known [NWORDS];
  pend_t       mon_p;
  logic [31:0] mon_exp;
  int          mon_lat;
  int          n_checks = 0;
  int          n_fail = 0;
  int          resp_count = 0;
  int          acc_count = 0;
  int          last_resp_cyc = -100;
  logic [31:0] last_rdata = 32'h0;
  bit          prev_resetn = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      check("addr_ok_in_reset", addr_ok, 1'b0);
      if (!prev_resetn) begin
        check("data_ok_in_reset", data_ok, 1'b0);
        check("rdata_in_reset", rdata, 32'h0);
      end
      acc_count     -= pend_q.size();
      pend_q.delete();
      last_resp_cyc = -100;
    end else begin
`ifndef SRAM_LIKE_RANDOM_STALL_EN
      check("addr_ok_vs_occupancy", addr_ok, pend_q.size() < DEPTH);
`endif
      if (data_ok) begin
        if (pend_q.size() == 0) begin
          fail_now("spurious_data_ok");
        end else begin
          mon_p = pend_q.pop_front();
          if (mon_p.wr) begin
            mon_exp = 32'h0;
            for (int b = 0; b < 4; b++)
              if (mon_p.wstrb[b]) ref_mem[mon_p.idx][8*b +: 8] = mon_p.wdata[8*b +: 8];
            if (mon_p.wstrb == 4'hF) ref_known[mon_p.idx] = 1'b1;
          end else begin
            mon_exp = ref_mem[mon_p.idx];
          end
          if (mon_p.wr || ref_known[mon_p.idx]) check("resp_rdata", rdata, mon_exp);
`ifndef SRAM_LIKE_RANDOM_STALL_EN
          // a response needs RD_LAT cycles after acceptance and after the previous response
          mon_lat = (mon_p.acc_cyc > last_resp_cyc) ? mon_p.acc_cyc : last_resp_cyc;
          check("resp_cycle", cyc, mon_lat + RD_LAT);
`endif
          last_resp_cyc = cyc;
          resp_count++;
          last_rdata = rdata;
          exp_q.push_back(rdata);
        end
      end else begin
        if (rdata !== 32'h0) fail_now("rdata_nonzero_without_data_ok");
      end
      if (req && addr_ok) begin
        pend_q.push_back('{wr, int'((addr >> 2) % NWORDS), wstrb, wdata, cyc});
        acc_count++;
      end
    end
    prev_resetn = resetn;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    int k;
    @(posedge clk); #1;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (addr_ok) break;
    end
    if (k == 100) fail_now("accept_timeout");
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (pend_q.size() == 0) break;
    end
    if (k == 300) fail_now("response_timeout");
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [12];
  logic [31:0] hold_addr [4];
  logic [31:0] hold_exp [4];
  int          hold_acc [4];
  int          hold_k;
  int          rc;
  int          sent;
  int          guard;
  int          n_rand;
  bit          accepted;
  int          ridx;

  initial begin
    vt[0]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,        32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h0000_1000, 4'h2, 32'h0000AB00, 32'h0};
    vt[3]  = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,        32'hDEADABEF};
    vt[4]  = '{1'b1, 32'h0000_1004, 4'hF, 32'h12345678, 32'h0};
    vt[5]  = '{1'b1, 32'h0000_1004, 4'h0, 32'hFFFFFFFF, 32'h0};
    vt[6]  = '{1'b0, 32'h0000_1007, 4'h0, 32'h0,        32'h12345678};
    vt[7]  = '{1'b1, 32'h0000_1008, 4'hF, 32'h00000000, 32'h0};
    vt[8]  = '{1'b1, 32'h0000_1008, 4'h9, 32'hA5A5A5A5, 32'h0};
    vt[9]  = '{1'b0, 32'h1000_1008, 4'h0, 32'h0,        32'hA50000A5};
    vt[10] = '{1'b1, 32'h0000_2000, 4'hF, 32'h11111111, 32'h0};
    vt[11] = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,        32'h11111111};

    // reset state
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
`ifndef SRAM_LIKE_RANDOM_STALL_EN
    check("addr_ok_after_reset", addr_ok, 1'b1);
`endif
    check("data_ok_after_reset", data_ok, 1'b0);
    check("rdata_after_reset", rdata, 32'h0);

    // directed table: one request at a time
    for (int i = 0; i < 12; i++) begin
      issue(vt[i].wr, vt[i].addr, vt[i].strb, vt[i].wdata);
      wait_idle();
      check($sformatf("vec%0d_rdata", i), last_rdata, vt[i].exp);
    end

    // req held high for four reads against a two-deep queue
    hold_addr = '{32'h1004, 32'h1008, 32'h1000, 32'h1007};
    hold_exp  = '{32'h12345678, 32'hA50000A5, 32'h11111111, 32'h12345678};
    exp_q.delete();
    hold_k = 0;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; wstrb = 4'h0; addr = hold_addr[0];
    for (int c = 0; c < 60 && hold_k < 4; c++) begin
      @(negedge clk);
      if (addr_ok) begin
        hold_acc[hold_k] = cyc;
        hold_k++;
      end
      @(posedge clk); #1;
      if (hold_k < 4) addr = hold_addr[hold_k];
      else            req = 1'b0;
    end
    req = 1'b0;
    check("hold_accept_count", hold_k, 4);
    wait_idle();
`ifndef SRAM_LIKE_RANDOM_STALL_EN
    // two fill the queue; each later slot opens the cycle after a pop (every RD_LAT)
    check("hold_acc1_offset", hold_acc[1] - hold_acc[0], 1);
    check("hold_acc2_offset", hold_acc[2] - hold_acc[0], 3);
    check("hold_acc3_offset", hold_acc[3] - hold_acc[0], 5);
`endif
    check("hold_resp_count", exp_q.size(), 4);
    for (int i = 0; i < 4 && i < exp_q.size(); i++)
      check($sformatf("hold_resp%0d", i), exp_q[i], hold_exp[i]);

    // reset while a write is still queued: it must vanish
    issue(1'b1, 32'h2000, 4'hF, 32'h99999999);
    resetn = 1'b0;
    rc = resp_count;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (RD_LAT + 4) @(negedge clk);
    check("no_resp_across_reset", resp_count, rc);
    issue(1'b0, 32'h2000, 4'h0, 32'h0);
    wait_idle();
    check("write_discarded_by_reset", last_rdata, 32'h11111111);

    // random traffic over eight words with random upper/low address bits
    for (int i = 0; i < 8; i++) issue(1'b1, 32'(i << 2), 4'hF, $urandom);
    wait_idle();
`ifdef SRAM_LIKE_RANDOM_STALL_EN
    n_rand = 1000;
`else
    n_rand = 400;
`endif
    sent  = 0;
    guard = 0;
    @(posedge clk); #1;
    while (sent < n_rand && guard < n_rand * 20) begin
      if (!req && $urandom_range(0, 3) != 0) begin
        ridx  = $urandom_range(0, 7);
        req   = 1'b1;
        wr    = 1'($urandom_range(0, 1));
        addr  = ($urandom & 32'hFFFF_F000) | 32'(ridx << 2) | 32'($urandom_range(0, 3));
        wstrb = 4'($urandom_range(0, 15));
        wdata = $urandom;
        size  = 2'($urandom_range(0, 2));
      end
      @(negedge clk);
      accepted = req && addr_ok;
      if (accepted) sent++;
      @(posedge clk); #1;
      if (accepted) req = 1'b0;
      guard++;
    end
    req = 1'b0;
    check("random_all_sent", sent, n_rand);
    wait_idle();
    check("no_lost_response", resp_count, acc_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
